// File: rtl/npu_seq_unit.sv
// npu_seq_unit: host doorbell decoder and instruction sequencer driving IM, a dual-port UB
// and the systolic array. Optional MOVE overlap trap: define NPU_SEQ_OVERLAP_CHECK_EN.
module npu_seq_unit #(
    parameter int                    ADDR_WIDTH       = 16,
    parameter int                    DATA_WIDTH       = 256,
    parameter logic [ADDR_WIDTH-1:0] IM_BASE          = 16'h8000,
    parameter int                    INST_STRIDE_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            cmd_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [ADDR_WIDTH-1:0] arg_in,
    input  logic [DATA_WIDTH-1:0] mmvr_in,
    input  logic                  doorbell_pulse,
    output logic [1:0]            status_out,
    output logic                  im_wr_en,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [DATA_WIDTH-1:0] im_wdata,
    input  logic [DATA_WIDTH-1:0] im_rdata,
    output logic [ADDR_WIDTH-1:0] ub_rd_addr,
    input  logic [DATA_WIDTH-1:0] ub_rdata,
    output logic                  ub_wr_en,
    output logic [ADDR_WIDTH-1:0] ub_wr_addr,
    output logic [DATA_WIDTH-1:0] ub_wdata,
    output logic                  acc_clear,
    output logic                  compute_enable
);
    localparam int A = ADDR_WIDTH;
    localparam int W = DATA_WIDTH;

    typedef enum logic [3:0] {
        S_IDLE, S_HWRITE, S_HREAD, S_FETCH, S_DECODE,
        S_MOVE, S_MM_CLR, S_MM_RUN, S_HALT, S_ERROR
    } state_t;

    localparam logic [1:0] CMD_WRITE = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_RUN   = 2'd2;
    localparam logic [1:0] CMD_ABORT = 2'd3;

    localparam logic [3:0] OP_HALT   = 4'd0;
    localparam logic [3:0] OP_NOP    = 4'd1;
    localparam logic [3:0] OP_MOVE   = 4'd2;
    localparam logic [3:0] OP_MATMUL = 4'd3;

    state_t       state, state_nxt;
    logic [A-1:0] pc, pc_nxt;
    logic [A-1:0] src, src_nxt;
    logic [A-1:0] dest, dest_nxt;
    logic [A-1:0] cnt, cnt_nxt;
    logic [A-1:0] idx, idx_nxt;
    logic [A-1:0] haddr, haddr_nxt;

    logic [3:0]   op;
    logic [A-1:0] f0, f1, f2;
    logic         abort;
    logic         host_im;
    logic         overlap;
    logic [A-1:0] fetch_addr;
    logic         unused_bits;

    assign op          = im_rdata[W-1 -: 4];
    assign f0          = im_rdata[W-9 -: A];
    assign f1          = im_rdata[W-9-A -: A];
    assign f2          = im_rdata[W-9-2*A -: A];
    assign unused_bits = ^{im_rdata[W-5:W-8], im_rdata[W-9-3*A:0]};

    assign abort      = doorbell_pulse && (cmd_in == CMD_ABORT) && (state != S_IDLE);
    assign host_im    = (haddr >= IM_BASE);
    assign fetch_addr = pc << INST_STRIDE_LOG2;

`ifdef NPU_SEQ_OVERLAP_CHECK_EN
    // dest below src means the range wrapped, so lift dest by 2^A before comparing.
    logic [A:0] src_x, end_x, dest_x;
    always_comb begin
        src_x   = {1'b0, f0};
        end_x   = src_x + {1'b0, f2};
        dest_x  = (f1 < f0) ? {1'b1, f1} : {1'b0, f1};
        overlap = (dest_x > src_x) && (dest_x < end_x);
    end
`else
    assign overlap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= '0;
            src   <= '0;
            dest  <= '0;
            cnt   <= '0;
            idx   <= '0;
            haddr <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            src   <= src_nxt;
            dest  <= dest_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            haddr <= haddr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        src_nxt   = src;
        dest_nxt  = dest;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        haddr_nxt = haddr;
        case (state)
            S_IDLE: if (doorbell_pulse) begin
                case (cmd_in)
                    CMD_WRITE: begin haddr_nxt = addr_in; state_nxt = S_HWRITE; end
                    CMD_READ:  begin haddr_nxt = addr_in; state_nxt = S_HREAD;  end
                    CMD_RUN:   begin pc_nxt = arg_in; state_nxt = S_FETCH; end
                    default: ;
                endcase
            end
            S_HWRITE, S_HREAD: state_nxt = S_IDLE;
            S_FETCH:           state_nxt = S_DECODE;
            S_DECODE: begin
                idx_nxt = '0;
                case (op)
                    OP_HALT: begin pc_nxt = pc + 1'b1; state_nxt = S_HALT; end
                    OP_NOP:  begin pc_nxt = pc + 1'b1; state_nxt = S_FETCH; end
                    OP_MOVE: begin
                        src_nxt  = f0;
                        dest_nxt = f1;
                        cnt_nxt  = f2;
                        if (overlap)         state_nxt = S_ERROR;
                        else if (f2 == '0) begin pc_nxt = pc + 1'b1; state_nxt = S_FETCH; end
                        else                 state_nxt = S_MOVE;
                    end
                    OP_MATMUL: begin
                        src_nxt = f0;
                        cnt_nxt = f2;
                        if (f2 == '0) begin pc_nxt = pc + 1'b1; state_nxt = S_FETCH; end
                        else               state_nxt = S_MM_CLR;
                    end
                    default: state_nxt = S_ERROR;
                endcase
            end
            // idx runs 0..cnt: reads lead writes by one cycle
            S_MOVE: begin
                if (idx == cnt) begin pc_nxt = pc + 1'b1; state_nxt = S_FETCH; end
                else idx_nxt = idx + 1'b1;
            end
            S_MM_CLR: begin idx_nxt = '0; state_nxt = S_MM_RUN; end
            S_MM_RUN: begin
                if (idx == cnt - 1'b1) begin pc_nxt = pc + 1'b1; state_nxt = S_FETCH; end
                else idx_nxt = idx + 1'b1;
            end
            S_HALT, S_ERROR: if (doorbell_pulse) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_comb begin
        status_out     = 2'd1;
        im_wr_en       = 1'b0;
        im_addr        = '0;
        im_wdata       = mmvr_in;
        ub_rd_addr     = '0;
        ub_wr_en       = 1'b0;
        ub_wr_addr     = '0;
        ub_wdata       = mmvr_in;
        acc_clear      = 1'b0;
        compute_enable = 1'b0;
        case (state)
            S_IDLE:  status_out = 2'd0;
            S_HALT:  status_out = 2'd2;
            S_ERROR: status_out = 2'd3;
            S_HWRITE: begin
                if (host_im) begin im_wr_en = 1'b1; im_addr = haddr - IM_BASE; end
                else begin ub_wr_en = 1'b1; ub_wr_addr = haddr; end
            end
            S_HREAD: begin
                if (host_im) im_addr    = haddr - IM_BASE;
                else         ub_rd_addr = haddr;
            end
            S_FETCH: im_addr = fetch_addr;
            S_MOVE: begin
                if (idx != cnt) ub_rd_addr = src + idx;
                if (idx != '0) begin
                    ub_wr_en   = 1'b1;
                    ub_wr_addr = dest + idx - 1'b1;
                    ub_wdata   = ub_rdata;
                end
            end
            S_MM_CLR: acc_clear = 1'b1;
            S_MM_RUN: begin
                compute_enable = 1'b1;
                ub_rd_addr     = src + idx;
            end
            default: ;
        endcase
        // an abort cancels any strobe of the cycle it arrives in
        if (abort) begin
            im_wr_en       = 1'b0;
            ub_wr_en       = 1'b0;
            acc_clear      = 1'b0;
            compute_enable = 1'b0;
        end
    end
endmodule

// File: tb/tb_npu_seq_unit.sv
// tb_npu_seq_unit: host commands and random programs checked every cycle against an
// expected-trace model built from the instruction semantics, plus literal spot checks.
module tb_npu_seq_unit;
    localparam int          W       = 256;
    localparam logic [15:0] IM_BASE = 16'h8000;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     cmd_in;
    logic [15:0]    addr_in, arg_in;
    logic [W-1:0]   mmvr_in;
    logic           doorbell_pulse;
    logic [1:0]     status_out;
    logic           im_wr_en;
    logic [15:0]    im_addr;
    logic [W-1:0]   im_wdata, im_rdata;
    logic [15:0]    ub_rd_addr;
    logic [W-1:0]   ub_rdata;
    logic           ub_wr_en;
    logic [15:0]    ub_wr_addr;
    logic [W-1:0]   ub_wdata;
    logic           acc_clear, compute_enable;

    npu_seq_unit dut (
        .clk(clk), .rst(rst), .cmd_in(cmd_in), .addr_in(addr_in), .arg_in(arg_in),
        .mmvr_in(mmvr_in), .doorbell_pulse(doorbell_pulse), .status_out(status_out),
        .im_wr_en(im_wr_en), .im_addr(im_addr), .im_wdata(im_wdata), .im_rdata(im_rdata),
        .ub_rd_addr(ub_rd_addr), .ub_rdata(ub_rdata), .ub_wr_en(ub_wr_en),
        .ub_wr_addr(ub_wr_addr), .ub_wdata(ub_wdata), .acc_clear(acc_clear),
        .compute_enable(compute_enable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   status;
        logic         im_wr_en;
        logic [15:0]  im_addr;
        logic [15:0]  ub_rd_addr;
        logic         ub_wr_en;
        logic [15:0]  ub_wr_addr;
        logic [W-1:0] wdata;
        logic         acc_clear;
        logic         compute_enable;
    } exp_t;

    exp_t         expq[$];
    int           n_checks = 0;
    int           n_fail = 0;
    logic [1:0]   cur_st;
    logic [W-1:0] mim[logic [15:0]];
    logic [W-1:0] dim[logic [15:0]];
    logic [W-1:0] prog[$];
    logic [15:0]  wr_log[$];
    logic [15:0]  ce_log[$];
    int           n_acc = 0;

    // UB content is a fixed function of address; IM is a plain memory written by the DUT
    function automatic logic [W-1:0] pat(input logic [15:0] a);
        logic [W-1:0] r;
        logic [31:0]  h;
        for (int k = 0; k < W / 32; k++) begin
            h = ({16'h0, a} ^ (32'(k) << 20)) * 32'h9E3779B1 + 32'h0BADF00D;
            r[k*32 +: 32] = h;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        im_rdata <= dim.exists(im_addr) ? dim[im_addr] : '0;
        ub_rdata <= pat(ub_rd_addr);
        if (im_wr_en) dim[im_addr] = im_wdata;
    end

    function automatic exp_t rec(input logic [1:0] st);
        exp_t e;
        e.status = st; e.im_wr_en = 1'b0; e.im_addr = '0; e.ub_rd_addr = '0;
        e.ub_wr_en = 1'b0; e.ub_wr_addr = '0; e.wdata = '0;
        e.acc_clear = 1'b0; e.compute_enable = 1'b0;
        return e;
    endfunction

    function automatic logic [W-1:0] enc(input logic [3:0] op, input logic [15:0] a, b, c);
        logic [W-1:0] w;
        for (int k = 0; k < W / 32; k++) w[k*32 +: 32] = $urandom;
        w[W-1 -: 4] = op; w[W-9 -: 16] = a; w[W-25 -: 16] = b; w[W-41 -: 16] = c;
        return w;
    endfunction

    function automatic bit overlap_bad(input logic [15:0] s, d, c);
        bit          en;
        logic [15:0] off;
`ifdef NPU_SEQ_OVERLAP_CHECK_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        off = d - s;
        return en && (off != 16'h0) && (off < c);
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // one clock: compare on the falling edge, return just after the rising edge
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (ub_wr_en) wr_log.push_back(ub_wr_addr);
        if (compute_enable) ce_log.push_back(ub_rd_addr);
        if (acc_clear) n_acc++;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("status", W'(status_out), W'(e.status));
            chk("im_wr_en", W'(im_wr_en), W'(e.im_wr_en));
            chk("im_addr", W'(im_addr), W'(e.im_addr));
            chk("ub_rd_addr", W'(ub_rd_addr), W'(e.ub_rd_addr));
            chk("ub_wr_en", W'(ub_wr_en), W'(e.ub_wr_en));
            chk("ub_wr_addr", W'(ub_wr_addr), W'(e.ub_wr_addr));
            chk("acc_clear", W'(acc_clear), W'(e.acc_clear));
            chk("compute_enable", W'(compute_enable), W'(e.compute_enable));
            if (e.im_wr_en) chk("im_wdata", im_wdata, e.wdata);
            if (e.ub_wr_en) chk("ub_wdata", ub_wdata, e.wdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int b = 0; b < 4000 && expq.size() > 0; b++) step();
        if (expq.size() > 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: %0d cycles still expected", expq.size());
            expq.delete();
        end
    endtask

    task automatic host(input logic [1:0] cmd, input logic [15:0] a, input logic [W-1:0] d);
        exp_t e;
        cmd_in = cmd; addr_in = a; mmvr_in = d; arg_in = 16'($urandom); doorbell_pulse = 1'b1;
        expq.push_back(rec(cur_st));
        if (cur_st != 2'd0) begin
            expq.push_back(rec(2'd0));
            cur_st = 2'd0;
        end else if (cmd == 2'd0 || cmd == 2'd1) begin
            e = rec(2'd1);
            e.wdata = d;
            if (a >= IM_BASE) begin
                e.im_addr = a - IM_BASE;
                e.im_wr_en = (cmd == 2'd0);
                if (cmd == 2'd0) mim[a - IM_BASE] = d;
            end else if (cmd == 2'd0) begin
                e.ub_wr_en = 1'b1; e.ub_wr_addr = a;
            end else begin
                e.ub_rd_addr = a;
            end
            expq.push_back(e);
            expq.push_back(rec(2'd0));
        end else begin
            expq.push_back(rec(2'd0));
        end
        step();
        doorbell_pulse = 1'b0;
        drain();
    endtask

    task automatic load(input logic [15:0] pc0);
        logic [15:0] p;
        for (int i = 0; i < prog.size(); i++) begin
            p = pc0 + 16'(i);
            host(2'd0, IM_BASE + (p << 2), prog[i]);
        end
    endtask

    // RUN from pc0; expected trace derived from each instruction's cycle cost
    task automatic run(input logic [15:0] pc0, input int abort_at);
        exp_t         t[$];
        exp_t         e;
        logic [15:0]  pc, ia, f0, f1, f2;
        logic [W-1:0] w;
        logic [3:0]   op;
        logic [1:0]   fin;
        bit           done;
        fin = 2'd0; done = 1'b0; pc = pc0;
        t.push_back(rec(2'd0));
        for (int n = 0; n < 64 && !done; n++) begin
            ia = pc << 2;
            e = rec(2'd1); e.im_addr = ia; t.push_back(e);
            t.push_back(rec(2'd1));
            w = mim.exists(ia) ? mim[ia] : '0;
            op = w[W-1 -: 4]; f0 = w[W-9 -: 16]; f1 = w[W-25 -: 16]; f2 = w[W-41 -: 16];
            case (op)
                4'd0: begin t.push_back(rec(2'd2)); fin = 2'd2; done = 1'b1; end
                4'd1: pc = pc + 16'd1;
                4'd2: begin
                    if (overlap_bad(f0, f1, f2)) begin
                        t.push_back(rec(2'd3)); fin = 2'd3; done = 1'b1;
                    end else begin
                        if (f2 != 16'd0)
                            for (int i = 0; i <= int'(f2); i++) begin
                                e = rec(2'd1);
                                if (i < int'(f2)) e.ub_rd_addr = f0 + 16'(i);
                                if (i >= 1) begin
                                    e.ub_wr_en = 1'b1;
                                    e.ub_wr_addr = f1 + 16'(i - 1);
                                    e.wdata = pat(f0 + 16'(i - 1));
                                end
                                t.push_back(e);
                            end
                        pc = pc + 16'd1;
                    end
                end
                4'd3: begin
                    if (f2 != 16'd0) begin
                        e = rec(2'd1); e.acc_clear = 1'b1; t.push_back(e);
                        for (int j = 0; j < int'(f2); j++) begin
                            e = rec(2'd1); e.compute_enable = 1'b1; e.ub_rd_addr = f0 + 16'(j);
                            t.push_back(e);
                        end
                    end
                    pc = pc + 16'd1;
                end
                default: begin t.push_back(rec(2'd3)); fin = 2'd3; done = 1'b1; end
            endcase
        end
        if (abort_at >= 1 && abort_at < t.size()) begin
            e = t[abort_at];
            e.im_wr_en = 1'b0; e.ub_wr_en = 1'b0; e.acc_clear = 1'b0; e.compute_enable = 1'b0;
            t[abort_at] = e;
            while (t.size() > abort_at + 1) void'(t.pop_back());
            t.push_back(rec(2'd0));
            fin = 2'd0;
        end
        foreach (t[i]) expq.push_back(t[i]);
        cur_st = fin;
        cmd_in = 2'd2; arg_in = pc0; addr_in = 16'($urandom); doorbell_pulse = 1'b1;
        step();
        for (int c = 1; c < 4000 && expq.size() > 0; c++) begin
            cmd_in = 2'd3;
            doorbell_pulse = (c == abort_at);
            step();
        end
        doorbell_pulse = 1'b0;
        drain();
    endtask

    task automatic clear_stop();
        if (cur_st != 2'd0) host(2'($urandom_range(0, 3)), 16'($urandom), '0);
    endtask

    initial begin
        int           base, cbase, abase;
        logic [W-1:0] p;
        cur_st = 2'd0;
        p = pat(16'hABCD);
        rst = 1'b1; cmd_in = 2'd2; addr_in = '0; arg_in = 16'h0055; mmvr_in = p;
        doorbell_pulse = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; doorbell_pulse = 1'b0;
        @(negedge clk);
        chk("rst_status", W'(status_out), W'(2'd0));
        chk("rst_enables", W'({im_wr_en, ub_wr_en, acc_clear, compute_enable}), W'(4'd0));
        chk("rst_addrs", W'({im_addr, ub_rd_addr, ub_wr_addr}), W'(48'd0));
        chk("rst_im_wdata", im_wdata, p);
        chk("rst_ub_wdata", ub_wdata, p);
        @(posedge clk); #1;

        base = wr_log.size();
        host(2'd0, 16'h0010, p);
        chk("hwrite_ub_addr", W'(wr_log[base]), W'(16'h0010));
        host(2'd1, 16'h0010, '0);
        chk("hread_status", W'(status_out), W'(2'd0));
        host(2'd0, 16'h8003, ~p);
        host(2'd3, 16'h0000, '0);

        prog = {enc(4'd2, 16'h0010, 16'h0040, 16'd4), enc(4'd2, 16'h0011, 16'h0077, 16'd0),
                enc(4'd0, 16'h0, 16'h0, 16'h0)};
        load(16'h0010);
        base = wr_log.size();
        run(16'h0010, -1);
        chk("move_writes", W'(wr_log.size() - base), W'(4));
        chk("move_first", W'(wr_log[base]), W'(16'h0040));
        chk("move_last", W'(wr_log[base + 3]), W'(16'h0043));
        chk("halt_status", W'(status_out), W'(2'd2));
        clear_stop();

        prog = {enc(4'd3, 16'h0020, 16'h0, 16'd8), enc(4'd0, 16'h0, 16'h0, 16'h0)};
        load(16'h0020);
        cbase = ce_log.size(); abase = n_acc;
        run(16'h0020, -1);
        chk("mm_clears", W'(n_acc - abase), W'(1));
        chk("mm_cycles", W'(ce_log.size() - cbase), W'(8));
        chk("mm_first", W'(ce_log[cbase]), W'(16'h0020));
        chk("mm_last", W'(ce_log[cbase + 7]), W'(16'h0027));
        clear_stop();

        prog = {enc(4'hF, 16'h1, 16'h2, 16'h3)};
        load(16'h0030);
        run(16'h0030, -1);
        chk("err_status", W'(status_out), W'(2'd3));
        base = wr_log.size();
        host(2'd0, 16'h0050, p);
        chk("err_clear_status", W'(status_out), W'(2'd0));
        chk("err_clear_nowrite", W'(wr_log.size() - base), W'(0));

        prog = {enc(4'd2, 16'h0100, 16'h0200, 16'd16), enc(4'd0, 16'h0, 16'h0, 16'h0)};
        load(16'h0040);
        base = wr_log.size();
        run(16'h0040, 5);
        chk("abort_writes", W'(wr_log.size() - base), W'(1));
        chk("abort_status", W'(status_out), W'(2'd0));

        prog = {enc(4'd2, 16'h0010, 16'h0012, 16'd4), enc(4'd0, 16'h0, 16'h0, 16'h0)};
        load(16'h0050);
        base = wr_log.size();
        run(16'h0050, -1);
`ifdef NPU_SEQ_OVERLAP_CHECK_EN
        chk("ovl_status", W'(status_out), W'(2'd3));
        chk("ovl_writes", W'(wr_log.size() - base), W'(0));
`else
        chk("ovl_status", W'(status_out), W'(2'd2));
        chk("ovl_writes", W'(wr_log.size() - base), W'(4));
`endif
        clear_stop();
        prog = {enc(4'd2, 16'hFFFE, 16'h0000, 16'd4), enc(4'd0, 16'h0, 16'h0, 16'h0)};
        load(16'h0058);
        base = wr_log.size();
        run(16'h0058, -1);
`ifdef NPU_SEQ_OVERLAP_CHECK_EN
        chk("wrap_ovl_status", W'(status_out), W'(2'd3));
`else
        chk("wrap_ovl_status", W'(status_out), W'(2'd2));
        chk("wrap_last", W'(wr_log[base + 3]), W'(16'h0003));
`endif
        clear_stop();

        // fetch address truncates: pc 0x4001 reads IM word 4
        prog = {enc(4'd1, 16'h0, 16'h0, 16'h0), enc(4'd0, 16'h0, 16'h0, 16'h0)};
        load(16'h0001);
        run(16'h4001, -1);
        chk("pcwrap_status", W'(status_out), W'(2'd2));
        clear_stop();

        for (int it = 0; it < 12; it++) begin
            logic [15:0] pc0;
            int          ab, r;
            for (int h = 0; h < 2; h++) begin
                r = $urandom_range(0, 2);
                host((r == 2) ? 2'd3 : 2'(r), 16'($urandom), {8{$urandom}});
            end
            prog.delete();
            for (int i = 0; i < $urandom_range(1, 5); i++) begin
                r = $urandom_range(0, 9);
                if (r < 3)      prog.push_back(enc(4'd1, 16'($urandom), 16'($urandom), 16'($urandom)));
                else if (r < 6) prog.push_back(enc(4'd2, 16'($urandom), 16'($urandom), 16'($urandom_range(0, 5))));
                else if (r < 9) prog.push_back(enc(4'd3, 16'($urandom), 16'($urandom), 16'($urandom_range(0, 5))));
                else            prog.push_back(enc(4'($urandom_range(4, 15)), 16'h0, 16'h0, 16'h0));
            end
            prog.push_back(enc(4'd0, 16'($urandom), 16'($urandom), 16'($urandom)));
            pc0 = 16'($urandom_range(16'h0060, 16'h1F00));
            load(pc0);
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : -1;
            run(pc0, ab);
            clear_stop();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
